// File: rtl/booth_alu.sv
// Signed ADD/SUB ALU (optional saturation) with a sequential radix-2 Booth multiplier.
// One request in flight at a time; valid/ready handshake on both sides.
module booth_alu #(
  parameter int WIDTH = 32,
  parameter bit SAT   = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           op,
  input  logic [WIDTH-1:0]     in1,
  input  logic [WIDTH-1:0]     in2,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   result,
  output logic                 ovf,
  output logic                 zero,
  output logic                 neg,
  output logic                 err
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t               state_reg, state_next;
  logic [WIDTH-1:0]     mcand_reg, mcand_next;
  logic [WIDTH:0]       a_reg, a_next;
  logic [WIDTH-1:0]     q_reg, q_next;
  logic                 q1_reg, q1_next;
  logic [CW-1:0]        cnt_reg, cnt_next;
  logic [2*WIDTH-1:0]   result_reg, result_next;
  logic                 ovf_reg, ovf_next;
  logic                 zero_reg, zero_next;
  logic                 neg_reg, neg_next;
  logic                 err_reg, err_next;

  logic                 load_res;
  logic [WIDTH-1:0]     sum_raw;
  logic                 as_ovf;
  logic [WIDTH-1:0]     as_val;
  logic [WIDTH:0]       m_ext;
  logic [WIDTH:0]       a_sum;

  // ADD/SUB path works straight off the request inputs since it completes at the accept edge
  always_comb begin
    sum_raw = (op == OP_SUB) ? (in1 - in2) : (in1 + in2);
    if (op == OP_SUB)
      as_ovf = (in1[WIDTH-1] != in2[WIDTH-1]) && (sum_raw[WIDTH-1] != in1[WIDTH-1]);
    else
      as_ovf = (in1[WIDTH-1] == in2[WIDTH-1]) && (sum_raw[WIDTH-1] != in1[WIDTH-1]);
    as_val = sum_raw;
    if (SAT && as_ovf)
      as_val = in1[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  end

  // One Booth step; A carries an extra sign bit so subtracting the most negative multiplicand cannot overflow
  always_comb begin
    m_ext = {mcand_reg[WIDTH-1], mcand_reg};
    case ({q_reg[0], q1_reg})
      2'b01:   a_sum = a_reg + m_ext;
      2'b10:   a_sum = a_reg - m_ext;
      default: a_sum = a_reg;
    endcase
  end

  always_comb begin
    state_next  = state_reg;
    mcand_next  = mcand_reg;
    a_next      = a_reg;
    q_next      = q_reg;
    q1_next     = q1_reg;
    cnt_next    = cnt_reg;
    result_next = result_reg;
    ovf_next    = ovf_reg;
    err_next    = err_reg;
    zero_next   = zero_reg;
    neg_next    = neg_reg;
    load_res    = 1'b0;

    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          case (op)
            OP_ADD, OP_SUB: begin
              result_next = {{WIDTH{as_val[WIDTH-1]}}, as_val};
              ovf_next    = as_ovf;
              err_next    = 1'b0;
              load_res    = 1'b1;
              state_next  = DONE;
            end
            OP_MUL: begin
              mcand_next = in1;
              a_next     = '0;
              q_next     = in2;
              q1_next    = 1'b0;
              cnt_next   = CW'(WIDTH);
              state_next = MUL;
            end
            default: begin
              result_next = '0;
              ovf_next    = 1'b0;
              err_next    = 1'b1;
              load_res    = 1'b1;
              state_next  = DONE;
            end
          endcase
        end
      end
      MUL: begin
        if (cnt_reg != '0) begin
          a_next   = {a_sum[WIDTH], a_sum[WIDTH:1]};
          q_next   = {a_sum[0], q_reg[WIDTH-1:1]};
          q1_next  = q_reg[0];
          cnt_next = cnt_reg - CW'(1);
        end else begin
          // All steps done: the product sits in the low bits of {A,Q}
          result_next = {a_reg[WIDTH-1:0], q_reg};
          ovf_next    = 1'b0;
          err_next    = 1'b0;
          load_res    = 1'b1;
          state_next  = DONE;
        end
      end
      DONE: begin
        if (out_ready)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    if (load_res) begin
      zero_next = (result_next == '0);
      neg_next  = result_next[2*WIDTH-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      mcand_reg  <= '0;
      a_reg      <= '0;
      q_reg      <= '0;
      q1_reg     <= 1'b0;
      cnt_reg    <= '0;
      result_reg <= '0;
      ovf_reg    <= 1'b0;
      zero_reg   <= 1'b0;
      neg_reg    <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      mcand_reg  <= mcand_next;
      a_reg      <= a_next;
      q_reg      <= q_next;
      q1_reg     <= q1_next;
      cnt_reg    <= cnt_next;
      result_reg <= result_next;
      ovf_reg    <= ovf_next;
      zero_reg   <= zero_next;
      neg_reg    <= neg_next;
      err_reg    <= err_next;
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign result    = result_reg;
  assign ovf       = ovf_reg;
  assign zero      = zero_reg;
  assign neg       = neg_reg;
  assign err       = err_reg;

endmodule

// File: tb/tb_booth_alu.sv
// Directed bench for booth_alu: 8-bit wrap and saturating instances share stimulus,
// a 32-bit instance covers the long multiply with back-pressure.
module tb_booth_alu;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        a_in_valid, a_out_ready;
  logic [1:0]  a_op;
  logic [7:0]  a_in1, a_in2;
  logic        w_in_ready, w_out_valid, w_ovf, w_zero, w_neg, w_err;
  logic [15:0] w_result;
  logic        s_in_ready, s_out_valid, s_ovf, s_zero, s_neg, s_err;
  logic [15:0] s_result;

  logic        b_in_valid, b_out_ready;
  logic [1:0]  b_op;
  logic [31:0] b_in1, b_in2;
  logic        b_in_ready, b_out_valid, b_ovf, b_zero, b_neg, b_err;
  logic [63:0] b_result;

  booth_alu #(.WIDTH(8), .SAT(1'b0)) u_wrap (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(w_in_ready), .op(a_op),
    .in1(a_in1), .in2(a_in2), .out_valid(w_out_valid), .out_ready(a_out_ready),
    .result(w_result), .ovf(w_ovf), .zero(w_zero), .neg(w_neg), .err(w_err));

  booth_alu #(.WIDTH(8), .SAT(1'b1)) u_sat (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(s_in_ready), .op(a_op),
    .in1(a_in1), .in2(a_in2), .out_valid(s_out_valid), .out_ready(a_out_ready),
    .result(s_result), .ovf(s_ovf), .zero(s_zero), .neg(s_neg), .err(s_err));

  booth_alu #(.WIDTH(32), .SAT(1'b0)) u_w32 (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .op(b_op),
    .in1(b_in1), .in2(b_in2), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .result(b_result), .ovf(b_ovf), .zero(b_zero), .neg(b_neg), .err(b_err));

  int n_checks = 0;
  int n_pass   = 0;
  int edges;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    a_in_valid = 1'b0; a_out_ready = 1'b0; a_op = 2'b00; a_in1 = '0; a_in2 = '0;
    b_in_valid = 1'b0; b_out_ready = 1'b0; b_op = 2'b00; b_in1 = '0; b_in2 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", w_in_ready, 1);
    chk("rst_out_valid", w_out_valid, 0);
    chk("rst_result", w_result, 0);
    chk("rst_zero", w_zero, 0);
    chk("rst_err", w_err, 0);
    rst = 1'b0;

    // ADD 100+50 overflows positive
    a_op = 2'b00; a_in1 = 8'd100; a_in2 = 8'd50; a_in_valid = 1'b1;
    tick();
    a_in_valid = 1'b0; a_in1 = 8'h11; a_in2 = 8'h22;
    chk("add_valid", w_out_valid, 1);
    chk("add_in_ready", w_in_ready, 0);
    chk("add_wrap_res", w_result, 16'hFF96);
    chk("add_wrap_ovf", w_ovf, 1);
    chk("add_wrap_neg", w_neg, 1);
    chk("add_sat_res", s_result, 16'h007F);
    chk("add_sat_ovf", s_ovf, 1);
    chk("add_sat_neg", s_neg, 0);
    tick();
    chk("add_hold_res", w_result, 16'hFF96);
    chk("add_hold_valid", w_out_valid, 1);
    a_out_ready = 1'b1;
    tick();
    a_out_ready = 1'b0;
    chk("add_rel_valid", w_out_valid, 0);
    chk("add_rel_in_ready", w_in_ready, 1);

    // SUB -128-1 overflows negative
    a_op = 2'b01; a_in1 = 8'h80; a_in2 = 8'h01; a_in_valid = 1'b1;
    tick();
    a_in_valid = 1'b0;
    chk("sub_wrap_res", w_result, 16'h007F);
    chk("sub_wrap_ovf", w_ovf, 1);
    chk("sub_sat_res", s_result, 16'hFF80);
    chk("sub_sat_ovf", s_ovf, 1);
    chk("sub_sat_neg", s_neg, 1);
    a_out_ready = 1'b1;
    tick();
    a_out_ready = 1'b0;

    // SUB 5-5
    a_op = 2'b01; a_in1 = 8'd5; a_in2 = 8'd5; a_in_valid = 1'b1;
    tick();
    a_in_valid = 1'b0;
    chk("sub0_res", w_result, 0);
    chk("sub0_zero", w_zero, 1);
    chk("sub0_ovf", w_ovf, 0);
    chk("sub0_sat_zero", s_zero, 1);
    a_out_ready = 1'b1;
    tick();
    a_out_ready = 1'b0;

    // MUL -128*-128, latency and input capture
    a_op = 2'b10; a_in1 = 8'h80; a_in2 = 8'h80; a_in_valid = 1'b1;
    tick();
    a_in_valid = 1'b0; a_in1 = 8'h01; a_in2 = 8'h01;
    chk("mul_busy_in_ready", w_in_ready, 0);
    edges = 0;
    while (!w_out_valid && edges < 20) begin
      tick();
      edges++;
    end
    chk("mul_latency", edges, 9);
    chk("mul_min_res", w_result, 16'h4000);
    chk("mul_min_ovf", w_ovf, 0);
    chk("mul_min_neg", w_neg, 0);
    chk("mul_min_err", w_err, 0);
    a_out_ready = 1'b1;
    tick();

    // MUL -7*6 with out_ready held high throughout: must not stall
    a_op = 2'b10; a_in1 = 8'hF9; a_in2 = 8'd6; a_in_valid = 1'b1;
    tick();
    a_in_valid = 1'b0;
    edges = 0;
    while (!w_out_valid && edges < 20) begin
      tick();
      edges++;
    end
    chk("mul_neg_latency", edges, 9);
    chk("mul_neg_res", w_result, 16'hFFD6);
    chk("mul_neg_neg", w_neg, 1);
    tick();
    chk("mul_neg_released", w_out_valid, 0);
    a_out_ready = 1'b0;

    // Reset on the 3rd MUL step aborts, then ADD 2+3
    a_op = 2'b10; a_in1 = 8'd5; a_in2 = 8'd3; a_in_valid = 1'b1;
    tick();
    a_in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_out_valid", w_out_valid, 0);
    chk("abort_in_ready", w_in_ready, 1);
    chk("abort_result", w_result, 0);
    a_op = 2'b00; a_in1 = 8'd2; a_in2 = 8'd3; a_in_valid = 1'b1;
    tick();
    a_in_valid = 1'b0;
    chk("abort_add_res", w_result, 16'd5);
    chk("abort_add_valid", w_out_valid, 1);
    a_out_ready = 1'b1;
    tick();
    a_out_ready = 1'b0;

    // Reserved opcode, then a back-to-back request held on in_valid
    a_op = 2'b11; a_in1 = 8'd9; a_in2 = 8'd9; a_in_valid = 1'b1;
    tick();
    chk("rsv_valid", w_out_valid, 1);
    chk("rsv_err", w_err, 1);
    chk("rsv_res", w_result, 0);
    chk("rsv_ovf", w_ovf, 0);
    a_op = 2'b00; a_in1 = 8'd7; a_in2 = 8'd8; a_out_ready = 1'b1;
    tick();
    a_out_ready = 1'b0;
    chk("b2b_not_taken", w_out_valid, 0);
    chk("b2b_in_ready", w_in_ready, 1);
    tick();
    a_in_valid = 1'b0;
    chk("b2b_valid", w_out_valid, 1);
    chk("b2b_res", w_result, 16'd15);
    chk("b2b_err", w_err, 0);
    a_out_ready = 1'b1;
    tick();
    a_out_ready = 1'b0;

    // 32-bit MUL 123456 * -789 with back-pressure
    b_op = 2'b10; b_in1 = 32'd123456; b_in2 = -32'sd789; b_in_valid = 1'b1;
    tick();
    b_in_valid = 1'b0; b_in1 = '0; b_in2 = '0;
    edges = 0;
    while (!b_out_valid && edges < 50) begin
      tick();
      edges++;
    end
    chk("mul32_latency", edges, 33);
    chk("mul32_res", b_result, -64'sd97406784);
    chk("mul32_neg", b_neg, 1);
    repeat (4) begin
      tick();
      chk("mul32_hold_res", b_result, -64'sd97406784);
      chk("mul32_hold_valid", b_out_valid, 1);
      chk("mul32_hold_in_ready", b_in_ready, 0);
    end
    b_out_ready = 1'b1;
    tick();
    b_out_ready = 1'b0;
    chk("mul32_rel_valid", b_out_valid, 0);
    chk("mul32_rel_in_ready", b_in_ready, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
